// File: rtl/clock_pkg.sv
// Shared state codes and counter-width helper for the clock setup sequencer.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SEC  = 2'd1,
      ST_MIN  = 2'd2,
      ST_HOUR = 2'd3
   } state_t;

   localparam int TICK_DIV_DEF      = 50_000_000;
   localparam int REPEAT_DLY_DEF    = 25_000_000;
   localparam int REPEAT_RATE_DEF   = 5_000_000;
   localparam int TIMEOUT_TICKS_DEF = 10;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int TICK_W_DEF   = cnt_width(TICK_DIV_DEF);
   localparam int REPEAT_W_DEF = cnt_width(REPEAT_DLY_DEF);

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with hold delay and auto-repeat; emits one-cycle pulses.
module btn_repeat
   import clock_pkg::*;
#(
   parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clear,
   output logic pulse
);

   localparam int RW = cnt_width((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic          prev_q;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          rep_q, rep_d;
   logic          rise;

   assign rise = btn & ~prev_q;

   always_comb begin
      pulse = 1'b0;
      cnt_d = cnt_q;
      rep_d = rep_q;
      if (clear || !btn) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (rise) begin
         pulse = 1'b1;
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (cnt_q == (rep_q ? RATE_LAST : DLY_LAST)) begin
         // First expiry ends the hold delay; later ones pace the repeat.
         pulse = 1'b1;
         cnt_d = '0;
         rep_d = 1'b1;
      end else begin
         cnt_d = cnt_q + RW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b0;
         cnt_q  <= '0;
         rep_q  <= 1'b0;
      end else begin
         prev_q <= btn;
         cnt_q  <= cnt_d;
         rep_q  <= rep_d;
      end
   end

endmodule

// File: rtl/clock_setup_ctrl.sv
// Run/setup sequencer: 1 Hz run tick, field selection, edit ticks and setup timeout.
module clock_setup_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV      = TICK_DIV_DEF,
   parameter int REPEAT_DLY    = REPEAT_DLY_DEF,
   parameter int REPEAT_RATE   = REPEAT_RATE_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic       display,
   output logic       setup_second,
   output logic       setup_minute,
   output logic       setup_hour,
   output logic       inc_dec,
   output logic       tick,
   output logic [1:0] field
);

   localparam int PW = cnt_width(TICK_DIV);
   localparam int TW = cnt_width(TIMEOUT_TICKS);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

   state_t        state_q, state_d;
   logic          mode_prev_q;
   logic [PW-1:0] pre_q, pre_d, to_pre_q, to_pre_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          display_q, display_d, sec_n_q, sec_n_d, min_n_q, min_n_d, hour_n_q, hour_n_d;
   logic          inc_dec_q, inc_dec_d, tick_q, tick_d;
   logic [1:0]    field_q, field_d;
   logic          mode_rise, in_setup, activity, timeout, edit_clear;
   logic          inc_pulse, dec_pulse, run_tick, edit_tick;

   assign mode_rise  = btn_mode & ~mode_prev_q;
   assign in_setup   = (state_q != ST_RUN);
   assign activity   = btn_mode | btn_inc | btn_dec;
   assign timeout    = in_setup & ~activity & (to_pre_q == PRE_LAST) & (to_cnt_q == TO_LAST);
   // Pressing both edit buttons, or any state change, freezes both repeaters.
   assign edit_clear = ~in_setup | mode_rise | timeout | (btn_inc & btn_dec);

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
      .clk(clk), .rst(rst), .btn(btn_inc), .clear(edit_clear), .pulse(inc_pulse)
   );

   btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
      .clk(clk), .rst(rst), .btn(btn_dec), .clear(edit_clear), .pulse(dec_pulse)
   );

   assign run_tick  = ~in_setup & ~mode_rise & (pre_q == PRE_LAST);
   assign edit_tick = in_setup & (inc_pulse | dec_pulse);

   always_comb begin
      state_d = state_q;
      if (mode_rise) begin
         state_d = state_t'(state_q + 2'd1);
      end else if (timeout) begin
         state_d = ST_RUN;
      end

      pre_d = '0;
      if (!in_setup && state_d == ST_RUN) begin
         pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      end

      to_pre_d = '0;
      to_cnt_d = '0;
      if (in_setup && !activity && !timeout) begin
         to_cnt_d = to_cnt_q;
         if (to_pre_q == PRE_LAST) begin
            to_cnt_d = to_cnt_q + TW'(1);
         end else begin
            to_pre_d = to_pre_q + PW'(1);
         end
      end

      // Guard keeps a late button change from producing back-to-back ticks.
      tick_d    = (run_tick | edit_tick) & ~tick_q;
      inc_dec_d = inc_dec_q;
      if (edit_tick && !tick_q) begin
         inc_dec_d = inc_pulse;
      end

      display_d = in_setup;
      sec_n_d   = (state_q != ST_SEC);
      min_n_d   = (state_q != ST_MIN);
      hour_n_d  = (state_q != ST_HOUR);
      field_d   = state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         mode_prev_q <= 1'b0;
         pre_q       <= '0;
         to_pre_q    <= '0;
         to_cnt_q    <= '0;
         display_q   <= 1'b0;
         sec_n_q     <= 1'b1;
         min_n_q     <= 1'b1;
         hour_n_q    <= 1'b1;
         inc_dec_q   <= 1'b1;
         tick_q      <= 1'b0;
         field_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= btn_mode;
         pre_q       <= pre_d;
         to_pre_q    <= to_pre_d;
         to_cnt_q    <= to_cnt_d;
         display_q   <= display_d;
         sec_n_q     <= sec_n_d;
         min_n_q     <= min_n_d;
         hour_n_q    <= hour_n_d;
         inc_dec_q   <= inc_dec_d;
         tick_q      <= tick_d;
         field_q     <= field_d;
      end
   end

   assign display      = display_q;
   assign setup_second = sec_n_q;
   assign setup_minute = min_n_q;
   assign setup_hour   = hour_n_q;
   assign inc_dec      = inc_dec_q;
   assign tick         = tick_q;
   assign field        = field_q;

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Scoreboard bench for clock_setup_ctrl: expected ticks are queued, a monitor pops on each tick.
module tb_clock_setup_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic       display, setup_second, setup_minute, setup_hour, inc_dec, tick;
   logic [1:0] field;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int at;
      bit chk_dir;
      bit dir;
   } exp_t;

   exp_t exp_q[$];

   clock_setup_ctrl #(
      .TICK_DIV(10), .REPEAT_DLY(20), .REPEAT_RATE(5), .TIMEOUT_TICKS(3)
   ) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .display(display), .setup_second(setup_second), .setup_minute(setup_minute),
      .setup_hour(setup_hour), .inc_dec(inc_dec), .tick(tick), .field(field)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every tick must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (tick === 1'b1) begin
         $display("tick cyc=%0d field=%0d inc_dec=%0b", cyc, field, inc_dec);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_tick: tick at cyc=%0d, required no tick", cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.at != cyc) begin
               failures++;
               $display("FAIL tick_time: tick at cyc=%0d, required cyc=%0d", cyc, e.at);
            end
            if (e.chk_dir) begin
               checks++;
               if (inc_dec !== e.dir) begin
                  failures++;
                  $display("FAIL tick_dir: cyc=%0d inc_dec=%0b, required %0b", cyc, inc_dec, e.dir);
               end
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_tick(input int at, input bit chk_dir, input bit dir);
      exp_t e;
      e.at = at;
      e.chk_dir = chk_dir;
      e.dir = dir;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: cyc=%0d got %0h, required %0h", name, cyc, got, want);
      end
   endtask

   task automatic check_outputs(input string tag, input logic disp,
                                input logic [2:0] setup_n, input logic [1:0] fld);
      check({tag, "_display"}, {3'b0, display}, {3'b0, disp});
      check({tag, "_setup_n"}, {1'b0, setup_hour, setup_minute, setup_second}, {1'b0, setup_n});
      check({tag, "_field"}, {2'b0, field}, {2'b0, fld});
      $display("state %s cyc=%0d display=%0b setup_n=%0b%0b%0b field=%0d",
               tag, cyc, display, setup_hour, setup_minute, setup_second, field);
   endtask

   task automatic pulse_mode();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: cyc=%0d, required completion", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int base, m, r, q, s;
      logic [2:0] sel_n;

      step(3);
      check_outputs("reset", 1'b0, 3'b111, 2'd0);
      check("reset_inc_dec", {3'b0, inc_dec}, 4'd1);
      check("reset_tick", {3'b0, tick}, 4'd0);

      // Idle in RUN: ticks 10, 20, 30 cycles after reset release.
      rst = 1'b0;
      base = cyc;
      expect_tick(base + 10, 1'b0, 1'b0);
      expect_tick(base + 20, 1'b0, 1'b0);
      expect_tick(base + 30, 1'b0, 1'b0);
      step(35);

      for (int i = 1; i <= 3; i++) begin
         pulse_mode();
         step(2);
         sel_n = 3'b111;
         sel_n[i-1] = 1'b0;
         check_outputs($sformatf("mode%0d", i), 1'b1, sel_n, 2'(i));
         step(1);
      end

      // Fourth press back to RUN; run tick 10 cycles after entry.
      m = cyc;
      pulse_mode();
      expect_tick(m + 11, 1'b0, 1'b0);
      step(2);
      check_outputs("back_run", 1'b0, 3'b111, 2'd0);
      step(10);

      // SEC: hold inc 40 cycles, then tap dec.
      pulse_mode();
      step(2);
      check_outputs("sec", 1'b1, 3'b110, 2'd1);
      r = cyc;
      btn_inc = 1'b1;
      expect_tick(r + 1, 1'b1, 1'b1);
      expect_tick(r + 21, 1'b1, 1'b1);
      expect_tick(r + 26, 1'b1, 1'b1);
      expect_tick(r + 31, 1'b1, 1'b1);
      expect_tick(r + 36, 1'b1, 1'b1);
      step(40);
      btn_inc = 1'b0;
      step(2);
      btn_dec = 1'b1;
      expect_tick(r + 43, 1'b1, 1'b0);
      step(1);
      btn_dec = 1'b0;
      step(2);

      // MIN: both held 30 cycles, then release dec.
      pulse_mode();
      step(2);
      q = cyc;
      check_outputs("min", 1'b1, 3'b101, 2'd2);
      check("min_inc_dec_hold", {3'b0, inc_dec}, 4'd0);
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      step(30);
      btn_dec = 1'b0;
      expect_tick(q + 50, 1'b1, 1'b1);
      step(22);
      btn_inc = 1'b0;
      step(2);

      // HOUR: idle until the setup timeout returns to RUN.
      pulse_mode();
      expect_tick(q + 95, 1'b0, 1'b0);
      step(2);
      check_outputs("hour", 1'b1, 3'b011, 2'd3);
      step(27);
      check_outputs("hour_pre_timeout", 1'b1, 3'b011, 2'd3);
      step(4);
      check_outputs("timeout_run", 1'b0, 3'b111, 2'd0);
      step(9);

      // Reset in the middle of a dec repeat drops the pending tick.
      s = cyc;
      pulse_mode();
      step(2);
      btn_dec = 1'b1;
      expect_tick(s + 4, 1'b1, 1'b0);
      step(20);
      rst = 1'b1;
      #1;
      check_outputs("mid_rst", 1'b0, 3'b111, 2'd0);
      check("mid_rst_inc_dec", {3'b0, inc_dec}, 4'd1);
      check("mid_rst_tick", {3'b0, tick}, 4'd0);
      btn_dec = 1'b0;
      step(2);
      rst = 1'b0;
      base = cyc;
      expect_tick(base + 10, 1'b0, 1'b0);
      expect_tick(base + 20, 1'b0, 1'b0);
      step(22);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_ticks: %0d expected ticks never seen, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_setup_ctrl.md
Name: clock_setup_ctrl

Overview:
- Mode and setup sequencer for the clock's time-field counters (seconds, minutes, hours).
- Generates the 1 Hz run tick and switches the counters between run and setup mode.
- Selects which field is being edited and turns the inc/dec buttons into single-cycle edit ticks with auto-repeat.
- Sits between the (already debounced, synchronous) front-panel buttons and the field counters.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per run tick; prescaler counts 0..TICK_DIV-1.
- REPEAT_DLY, 25_000_000: cycles an inc/dec button is held before auto-repeat starts.
- REPEAT_RATE, 5_000_000: cycles between auto-repeat ticks.
- TIMEOUT_TICKS, 10: prescaler periods with no button activity in setup before forced return to RUN.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- btn_mode  in  1  mode button level, debounced, synchronous to clk.
- btn_inc  in  1  increment button level, debounced, synchronous to clk.
- btn_dec  in  1  decrement button level, debounced, synchronous to clk.
- display  out  1  0 = run (counters advance on tick), 1 = setup.
- setup_second  out  1  active-low edit enable, seconds field.
- setup_minute  out  1  active-low edit enable, minutes field.
- setup_hour  out  1  active-low edit enable, hours field.
- inc_dec  out  1  edit direction, shared by all fields: 1 = increment, 0 = decrement.
- tick  out  1  single-cycle pulse to the counters: run tick, or edit tick in setup.
- field  out  2  current state code: 0 RUN, 1 SEC, 2 MIN, 3 HOUR (for display blinking).

Behaviour:
- Reset values: state RUN, display 0, setup_* all 1, inc_dec 1, tick 0, field 0; prescaler, repeat and timeout counters 0; button history registers 0.
- Edge detect: button registers are sampled every cycle; rise = level & ~previous.
- FSM: RUN -> SEC -> MIN -> HOUR -> RUN, advancing one step on each btn_mode rise.
  - In RUN only btn_mode is acted on.
  - All outputs are registered from state, so an output change appears one cycle after the state register updates.
- Decode:
  - display = 1 in SEC, MIN and HOUR.
  - Exactly one setup_* is low in setup; all are 1 in RUN.
- Run tick:
  - The prescaler counts only in RUN.
  - tick is high for 1 cycle when the prescaler wraps from TICK_DIV-1 to 0.
  - On entry to RUN the prescaler clears, so the first tick comes TICK_DIV cycles after entry.
- Edit tick (setup states only), handled per button:
  - Rise: tick is high in the cycle after the rise is sampled, and the repeat counter clears.
  - While held: after REPEAT_DLY further cycles, tick is pulsed, then again every REPEAT_RATE cycles until release.
  - inc_dec is set to 1 or 0 in the same cycle as the tick it qualifies, and holds that value afterwards.
- Boundary conditions:
  - inc and dec both high: no ticks; both repeat counters are held at 0 until one is released. The remaining button then restarts its REPEAT_DLY wait; it is not treated as a new rise.
  - btn_mode rise coinciding with an edit event: the mode change wins and no tick is issued that cycle. Repeat counters clear on every state change.
  - Timeout: any button rise or held button in setup resets the timeout counter. Otherwise the counter increments once per TICK_DIV cycles (a separate prescaler that runs in setup). At TIMEOUT_TICKS the FSM returns to RUN with no tick.
  - Field limits and wrap-around (59->0, 0->59, 23->0) are owned by the counters; this block never inspects time values.
  - tick is never high on two consecutive cycles.
  - rst mid-setup: immediate return to all reset values; a pending tick is dropped.

Decomposition:
- Shared package clock_pkg: state/field codes (RUN=0, SEC=1, MIN=2, HOUR=3), width localparams for the prescaler and repeat counters (derived via $clog2 of the parameters).
- One sub-module, btn_repeat (edge detect plus hold-delay and repeat counter, outputs a pulse), instantiated once for btn_inc and once for btn_dec.
- The FSM, tick mux, timeout logic and output registers stay in clock_setup_ctrl.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=10, REPEAT_DLY=20, REPEAT_RATE=5, TIMEOUT_TICKS=3.
- Reset, then idle 35 cycles -> display=0, setup_*=1, tick pulses at cycles 10, 20, 30 only, each 1 cycle wide.
- Three btn_mode pulses spaced 4 cycles apart -> field 1, 2, 3 with setup_second, setup_minute, setup_hour low in turn. A fourth pulse -> field 0, display 0, and the next tick arrives 10 cycles later.
- In SEC, hold btn_inc 40 cycles -> ticks at +1, +21, +26, +31, +36 relative to the sampled rise, inc_dec=1 throughout. Then tap btn_dec -> one tick with inc_dec=0.
- In MIN, hold btn_inc and btn_dec together 30 cycles -> no tick. Release dec -> first tick 20 cycles later, with no tick at the release itself.
- In HOUR, no buttons for 30 cycles -> FSM returns to RUN with no tick. Separately, assert rst mid-repeat -> all outputs at reset values on the same edge.
